// File: rtl/multicycle_control_unit_if.sv
// Memory port between the multicycle control unit (master) and the memory
// or arbiter (slave): request, write enable and address select out, ready back.
interface multicycle_control_unit_if;
  logic mem_req;
  logic mem_we;
  logic adr_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  adr_src,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback,
// handles the shared memory handshake with a wait timeout, and traps stickily.
module multicycle_control_unit #(
  parameter int OP_W        = 4,
  parameter int FUNC_W      = 4,
  parameter int ALU_CTRL_W  = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OP_W-1:0]       op,
  input  logic [FUNC_W-1:0]     func,
  input  logic                  zero,
  input  logic                  neg,
  multicycle_control_unit_if.master mem,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            imm_src,
  output logic                  l_sel,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  retire,
  output logic                  illegal,
  output logic                  bus_err
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT) : '0;
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);

  localparam logic [OP_W-1:0] OP_ALU    = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OP_UNARY  = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] OP_JUMP   = OP_W'(4'b0011);
  localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(4'b0100);
  localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(4'b0111);
  localparam logic [OP_W-1:0] OP_STORE  = OP_W'(4'b1000);

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_BRANCH,
    S_JUMP,
    S_MEM_RD,
    S_LOAD_WB,
    S_MEM_WR,
    S_TRAP
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             unary_reg, unary_next;
  logic             illegal_reg, illegal_next;
  logic             bus_err_reg, bus_err_next;

  logic mem_active;
  logic timeout_hit;
  logic taken;
  logic unused_func;

  assign unused_func = ^func;

  assign mem_active  = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) ||
                       (state_reg == S_MEM_WR);
  // Ready in the limit cycle still wins: the timeout only fires on a not-ready cycle.
  assign timeout_hit = TIMEOUT_EN && mem_active && !mem.mem_ready &&
                       (wait_cnt_reg == CNT_MAX);

  always_comb begin
    case (func[2:0])
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b010:  taken = neg;
      3'b011:  taken = ~neg;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_RESET;
      wait_cnt_reg <= '0;
      unary_reg    <= 1'b0;
      illegal_reg  <= 1'b0;
      bus_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      unary_reg    <= unary_next;
      illegal_reg  <= illegal_next;
      bus_err_reg  <= bus_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    unary_next   = unary_reg;
    illegal_next = illegal_reg;
    bus_err_next = bus_err_reg;
    case (state_reg)
      S_RESET: state_next = S_FETCH;
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (mem.mem_ready) begin
          case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_MEM_RD: state_next = S_LOAD_WB;
            default:  state_next = S_FETCH;
          endcase
        end else if (timeout_hit) begin
          state_next   = S_TRAP;
          bus_err_next = 1'b1;
        end
      end
      S_DECODE: begin
        unary_next = (op == OP_UNARY);
        case (op)
          OP_ALU, OP_UNARY: state_next = S_EXEC_R;
          OP_BRANCH:        state_next = S_BRANCH;
          OP_JUMP:          state_next = S_JUMP;
          OP_LOAD:          state_next = S_MEM_RD;
          OP_STORE:         state_next = S_MEM_WR;
          default: begin
            state_next   = S_TRAP;
            illegal_next = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_BRANCH, S_JUMP, S_LOAD_WB: state_next = S_FETCH;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_RESET;
    endcase
  end

  // The counter saturates at the limit and restarts whenever the wait ends.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if ((state_next != state_reg) || !mem_active || mem.mem_ready) begin
      wait_cnt_next = '0;
    end else if (wait_cnt_reg != CNT_MAX) begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.adr_src = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    imm_src     = 2'b00;
    l_sel       = 1'b0;
    alu_ctrl    = '0;
    retire      = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        // Reset overrides a completing handshake, so no IR/PC load under rst.
        ir_write    = mem.mem_ready & ~rst;
        pc_write    = mem.mem_ready & ~rst;
      end
      S_EXEC_R: begin
        reg_write = 1'b1;
        alu_ctrl  = func[ALU_CTRL_W-1:0];
        l_sel     = unary_reg;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        imm_src  = 2'b01;
        pc_src   = 1'b1;
        pc_write = taken;
        retire   = 1'b1;
      end
      S_JUMP: begin
        imm_src  = 2'b01;
        pc_src   = 1'b1;
        pc_write = 1'b1;
        l_sel    = 1'b1;
        retire   = 1'b1;
      end
      S_MEM_RD: begin
        mem.mem_req = 1'b1;
        mem.adr_src = 1'b1;
      end
      S_LOAD_WB: begin
        reg_write  = 1'b1;
        result_src = 2'b10;
        retire     = 1'b1;
      end
      S_MEM_WR: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        mem.adr_src = 1'b1;
        retire      = mem.mem_ready & ~rst;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_reg;
  assign bus_err = bus_err_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised scoreboard bench: the driver pushes the expected per-cycle control
// vector computed from instruction-level rules; a monitor pops and compares.
module tb_multicycle_control_unit;

  localparam int MEM_TIMEOUT = 15;
  localparam logic [3:0] OP_ALU = 4'd0, OP_UNARY = 4'd1, OP_JUMP = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4, OP_LOAD = 4'd7, OP_STORE = 4'd8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] op = '0;
  logic [3:0] func = '0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;
  logic       ir_write, pc_write, pc_src, reg_write, l_sel, retire, illegal, bus_err;
  logic [1:0] result_src, imm_src;
  logic [2:0] alu_ctrl;

  multicycle_control_unit_if mem_bus ();

  multicycle_control_unit #(
    .OP_W(4), .FUNC_W(4), .ALU_CTRL_W(3), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .neg(neg),
    .mem(mem_bus.master),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .result_src(result_src), .imm_src(imm_src),
    .l_sel(l_sel), .alu_ctrl(alu_ctrl), .retire(retire),
    .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       l_sel;
    logic [2:0] alu_ctrl;
    logic       retire;
    logic       illegal;
    logic       bus_err;
  } outv_t;

  outv_t exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;
  logic  ill_m = 1'b0;
  logic  be_m = 1'b0;
  logic [3:0] op_drv = '0;
  logic [3:0] func_drv = '0;
  int    instr_n = 0;

  // One clock of stimulus plus the control vector expected during that clock.
  task automatic tick(input logic r, input logic rdy, input logic z, input logic n,
                      input outv_t e, input string tag);
    @(posedge clk);
    #1;
    rst = r;
    mem_bus.mem_ready = rdy;
    zero = z;
    neg = n;
    op = op_drv;
    func = func_drv;
    e.illegal = ill_m;
    e.bus_err = be_m;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic quiet(input outv_t e, input string tag);
    tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), e, tag);
  endtask

  // Handshake with ready on wait cycle w; more than MEM_TIMEOUT waits is a bus error.
  task automatic mem_phase(input outv_t base, input outv_t extra, input int w,
                           input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= MEM_TIMEOUT; i++) begin
      if (i == w) begin
        tick(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             outv_t'(base | extra), tag);
        ok = 1'b1;
        return;
      end
      tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), base, tag);
    end
    be_m = 1'b1;
  endtask

  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++) quiet('0, "trap_hold");
  endtask

  task automatic do_reset();
    tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, "rst_cycle");
    ill_m = 1'b0;
    be_m  = 1'b0;
    quiet('0, "reset_state");
  endtask

  task automatic run(input logic [3:0] o, input logic [3:0] f, input int fw, input int mw,
                     input logic z, input logic n);
    outv_t e;
    outv_t x;
    bit    ok;
    bit    trapped;
    bit    tk;
    op_drv   = o;
    func_drv = f;
    trapped  = 1'b0;
    e = '0; e.mem_req = 1'b1;
    x = '0; x.ir_write = 1'b1; x.pc_write = 1'b1;
    mem_phase(e, x, fw, "fetch", ok);
    if (!ok) begin
      trapped = 1'b1;
    end else begin
      quiet('0, "decode");
      e = '0;
      case (o)
        OP_ALU, OP_UNARY: begin
          e.reg_write = 1'b1; e.alu_ctrl = f[2:0];
          e.l_sel = (o == OP_UNARY); e.retire = 1'b1;
          quiet(e, "exec_r");
        end
        OP_BRANCH: begin
          case (f[2:0])
            3'd0:    tk = z;
            3'd1:    tk = !z;
            3'd2:    tk = n;
            3'd3:    tk = !n;
            default: tk = 1'b0;
          endcase
          e.imm_src = 2'b01; e.pc_src = 1'b1; e.pc_write = tk; e.retire = 1'b1;
          tick(1'b0, 1'($urandom_range(0, 1)), z, n, e, "branch");
        end
        OP_JUMP: begin
          e.imm_src = 2'b01; e.pc_src = 1'b1; e.pc_write = 1'b1;
          e.l_sel = 1'b1; e.retire = 1'b1;
          quiet(e, "jump");
        end
        OP_LOAD: begin
          e.mem_req = 1'b1; e.adr_src = 1'b1;
          mem_phase(e, '0, mw, "mem_rd", ok);
          if (ok) begin
            e = '0; e.reg_write = 1'b1; e.result_src = 2'b10; e.retire = 1'b1;
            quiet(e, "load_wb");
          end else begin
            trapped = 1'b1;
          end
        end
        OP_STORE: begin
          e.mem_req = 1'b1; e.mem_we = 1'b1; e.adr_src = 1'b1;
          x = '0; x.retire = 1'b1;
          mem_phase(e, x, mw, "mem_wr", ok);
          trapped = !ok;
        end
        default: begin
          ill_m   = 1'b1;
          trapped = 1'b1;
        end
      endcase
    end
    instr_n++;
    $display("instr %0d op=%h func=%h fetch_wait=%0d mem_wait=%0d trapped=%0b",
             instr_n, o, f, fw, mw, trapped);
    if (trapped) begin
      trap_hold(10);
      do_reset();
    end
  endtask

  function automatic int wait_pick();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 60) return 0;
    if (r < 85) return int'($urandom_range(1, 4));
    if (r < 93) return MEM_TIMEOUT;
    return MEM_TIMEOUT + 1;
  endfunction

  // Monitor: compares the DUT's control vector against the scoreboard each cycle.
  initial begin
    outv_t a;
    outv_t e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {mem_bus.mem_req, mem_bus.mem_we, mem_bus.adr_src, ir_write, pc_write,
             pc_src, reg_write, result_src, imm_src, l_sel, alu_ctrl, retire,
             illegal, bus_err};
        checks++;
        if (a !== e)
          begin
            errors++;
            $display("FAIL %s @%0t: actual=%05h required=%05h (mem_req..bus_err)",
                     t, $time, a, e);
          end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] legal_ops[6] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd7, 4'd8};
    logic [3:0] bad_ops[10]  = '{4'd2, 4'd5, 4'd6, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    outv_t e;
    outv_t x;
    bit    ok;
    logic [3:0] o;
    mem_bus.mem_ready = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0, "reset");
    tick(1'b1, 1'b1, 1'b0, 1'b0, '0, "reset");
    quiet('0, "reset_state");

    run(OP_ALU, 4'b0010, 0, 0, 1'b0, 1'b0);
    run(OP_BRANCH, 4'b0001, 0, 0, 1'b0, 1'b0);
    run(OP_BRANCH, 4'b0001, 0, 0, 1'b1, 1'b0);
    run(OP_BRANCH, 4'b0010, 0, 0, 1'b0, 1'b1);
    run(OP_BRANCH, 4'b0010, 0, 0, 1'b1, 1'b0);
    run(OP_BRANCH, 4'b0011, 0, 0, 1'b0, 1'b0);
    run(OP_BRANCH, 4'b0011, 0, 0, 1'b1, 1'b1);
    run(OP_BRANCH, 4'b1000, 0, 0, 1'b1, 1'b1);
    run(OP_BRANCH, 4'b0110, 0, 0, 1'b1, 1'b1);
    run(OP_LOAD, 4'b0000, 0, 3, 1'b0, 1'b0);
    run(OP_STORE, 4'b0000, 0, 1000, 1'b0, 1'b0);
    run(OP_STORE, 4'b0000, 0, MEM_TIMEOUT, 1'b0, 1'b0);
    run(4'b1111, 4'b0000, 0, 0, 1'b0, 1'b0);
    run(OP_JUMP, 4'b0101, 2, 0, 1'b0, 1'b0);
    run(OP_UNARY, 4'b1111, 0, 0, 1'b0, 1'b0);

    // Reset during a completing store: no retire, then back through RESET.
    op_drv = OP_STORE;
    func_drv = 4'b0000;
    e = '0; e.mem_req = 1'b1;
    x = '0; x.ir_write = 1'b1; x.pc_write = 1'b1;
    mem_phase(e, x, 0, "fetch", ok);
    quiet('0, "decode");
    e = '0; e.mem_req = 1'b1; e.mem_we = 1'b1; e.adr_src = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 1'b0, e, "rst_mid_store");
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0, "rst_mid_store_reset");
    $display("instr %0d store interrupted by reset", ++instr_n);

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 19) == 0) o = bad_ops[$urandom_range(0, 9)];
      else o = legal_ops[$urandom_range(0, 5)];
      run(o, 4'($urandom_range(0, 15)), wait_pick(), wait_pick(),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d required=0 pending entries", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
